arb_req_buf: RTL and testbench
==============================

ARB_REQ_BUF -- requirements
Module: arb_req_buf

Interface
REQ-001 SHALL have parameter RWID, default 4, number of requesters.
REQ-002 SHALL have parameter DW, default 8, payload width per requester.
REQ-003 SHALL have parameter DEPTH, default 2, per-requester queue entries; a power of two and at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid_i  input  RWID  per-requester payload valid.
REQ-007 SHALL have port in_ready_o  output  RWID  per-requester queue not full.
REQ-008 SHALL have port in_data_i  input  RWID x DW  per-requester payload.
REQ-009 SHALL have port req_o  output  RWID  request vector to the round-robin arbiter; bit i means queue i is non-empty.
REQ-010 SHALL have port gnt_i  input  RWID  one-hot grant from the arbiter.
REQ-011 SHALL have port out_valid_o  output  1  output register holds a payload.
REQ-012 SHALL have port out_ready_i  input  1  downstream accepts the payload.
REQ-013 SHALL have port out_data_o  output  DW  granted payload.
REQ-014 SHALL have port out_id_o  output  clog2(RWID)  index of the requester that supplied out_data_o.
REQ-015 SHALL have port gnt_err_o  output  1  one-cycle pulse on an illegal grant.

Function
REQ-016 SHALL keep one FIFO per requester; a push occurs when in_valid_i[i] and in_ready_o[i] are both high.
REQ-017 SHALL drive in_ready_o[i] = !full[i] & !reset, from registered state only, with no path from out_ready_i or gnt_i.
REQ-018 SHALL drive req_o[i] = !empty[i] from registered state; a push in cycle N raises req_o[i] in cycle N+1.
REQ-019 SHALL define take = gnt_i one-hot & (gnt_i & req_o) != 0 & (!out_valid_o | out_ready_i).
REQ-020 On take, SHALL load the head of the granted FIFO into out_data_o, load its index into out_id_o, set out_valid_o, and pop that FIFO in the same edge.
REQ-021 Without take, SHALL clear out_valid_o when out_ready_i is high; otherwise it SHALL hold out_valid_o, out_data_o and out_id_o stable.
REQ-022 A grant in cycle N SHALL produce out_valid_o in cycle N+1; the minimum push-to-output latency is 2 cycles.
REQ-023 SHALL preserve per-requester ordering; no payload is dropped or duplicated.
REQ-024 On a simultaneous push and pop of the same non-full FIFO, the occupancy SHALL stay unchanged and both operations SHALL take effect.
REQ-025 A full FIFO that is popped SHALL accept a push no earlier than the following cycle.
REQ-026 If gnt_i is multi-hot, or is one-hot to an empty requester, the block SHALL not pop and SHALL pulse gnt_err_o in the next cycle.
REQ-027 gnt_i = 0 SHALL be legal and idle, and SHALL not raise gnt_err_o.
REQ-028 A legal grant while the output is stalled SHALL be ignored without an error.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be held in clog2(DEPTH)+1 bits.

Reset
REQ-030 When reset is high at an edge, all FIFOs SHALL empty, and out_valid_o, gnt_err_o and req_o SHALL be 0; out_data_o and out_id_o SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued and output payloads; pushes presented during reset SHALL be dropped.

Structure
REQ-032 Package arb_pkg SHALL hold the default RWID and DW and the id-width helper function.
REQ-033 Each per-requester queue SHALL be an instance of sub-module arb_req_fifo (DW, DEPTH), exposing push, pop, head, full and empty.

Verification (RWID=4, DW=8, DEPTH=2)
REQ-034 Hold reset for 2 cycles with in_valid_i=4'hF -> req_o=0 and out_valid_o=0; after release, in_ready_o=4'hF and no payload has been accepted.
REQ-035 Push 0xA5 on requester 2 -> next cycle req_o=4'b0100; then drive gnt_i=4'b0100 -> next cycle out_valid_o=1, out_data_o=0xA5, out_id_o=2, req_o=0.
REQ-036 Push 0x11, 0x22, 0x33 back-to-back on requester 0 -> in_ready_o[0]=0 after two pushes and 0x33 is not accepted; draining yields 0x11 then 0x22.
REQ-037 Hold out_valid_o=1 with out_ready_i=0 and gnt_i=4'b0001 pending -> no pop, output stable, gnt_err_o=0.
REQ-038 Drive gnt_i=4'b0011, then gnt_i=4'b1000 with queue 3 empty -> no pops and one gnt_err_o pulse for each.
REQ-039 Connect to the round-robin arbiter with all four queues full and out_ready_i=1 -> 8 outputs with no loss, per-id order preserved, and every id served within any 4 consecutive takes.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared defaults and helpers for the arbitrated request buffer.
package arb_pkg;

  localparam int unsigned RWID_DEF = 4;
  localparam int unsigned DW_DEF   = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Per-requester circular queue; head/full/empty decode from registered state.
module arb_req_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Overflow and underflow requests are ignored rather than corrupting state.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only entries covered by count are ever read out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/arb_req_buf.sv
// Per-requester queues feeding an external arbiter, with a registered output stage.
module arb_req_buf
  import arb_pkg::*;
#(
  parameter int unsigned RWID  = RWID_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [RWID-1:0]           in_valid_i,
  output logic [RWID-1:0]           in_ready_o,
  input  logic [RWID-1:0][DW-1:0]   in_data_i,
  output logic [RWID-1:0]           req_o,
  input  logic [RWID-1:0]           gnt_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DW-1:0]             out_data_o,
  output logic [id_w(RWID)-1:0]     out_id_o,
  output logic                      gnt_err_o
);

  localparam int unsigned IDW = id_w(RWID);

  logic [RWID-1:0]         full;
  logic [RWID-1:0]         empty;
  logic [RWID-1:0]         push;
  logic [RWID-1:0]         pop;
  logic [RWID-1:0][DW-1:0] head;
  logic                    gnt_any;
  logic                    gnt_onehot;
  logic                    gnt_hit;
  logic                    out_free;
  logic                    take;
  logic                    gnt_bad;
  logic [IDW-1:0]          gnt_idx;

  // Ready and request depend only on queue state (and reset), never on grant or downstream.
  assign in_ready_o = ~full & {RWID{~reset}};
  assign req_o      = ~empty;
  assign push       = in_valid_i & in_ready_o;

  // One queue per requester.
  for (genvar g = 0; g < RWID; g++) begin : g_fifo
    arb_req_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[g]),
      .pop       (pop[g]),
      .push_data (in_data_i[g]),
      .head      (head[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  // Grant qualification: a legal grant is one-hot onto a non-empty queue.
  assign gnt_any    = |gnt_i;
  assign gnt_onehot = gnt_any && ((gnt_i & (gnt_i - RWID'(1))) == '0);
  assign gnt_hit    = |(gnt_i & req_o);
  assign out_free   = ~out_valid_o | out_ready_i;
  assign take       = gnt_onehot & gnt_hit & out_free;
  assign gnt_bad    = gnt_any & ~(gnt_onehot & gnt_hit);
  assign pop        = take ? gnt_i : '0;

  // Encode the one-hot grant into a requester index.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < RWID; i++) begin
      if (gnt_i[i]) gnt_idx = IDW'(i);
    end
  end

  // Output register: load on take, drain on accept, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_id_o    <= '0;
      gnt_err_o   <= 1'b0;
    end else begin
      gnt_err_o <= gnt_bad;
      if (take) begin
        out_valid_o <= 1'b1;
        out_data_o  <= head[gnt_idx];
        out_id_o    <= gnt_idx;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_req_buf.sv
// Directed bench for arb_req_buf with a per-requester expected-data scoreboard.
module tb_arb_req_buf;

  localparam int unsigned RWID  = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2;

  logic                    clk;
  logic                    reset;
  logic [RWID-1:0]         in_valid_i;
  logic [RWID-1:0]         in_ready_o;
  logic [RWID-1:0][DW-1:0] in_data_i;
  logic [RWID-1:0]         req_o;
  logic [RWID-1:0]         gnt_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [DW-1:0]           out_data_o;
  logic [1:0]              out_id_o;
  logic                    gnt_err_o;

  int         checks = 0;
  int         errors = 0;
  int         n_out  = 0;
  logic [7:0] exp_q [4][$];
  logic [1:0] xfer_ids [$];

  arb_req_buf #(.RWID(RWID), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_id_o    (out_id_o),
    .gnt_err_o   (gnt_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; an output handshake seen before the edge is scored after it.
  task automatic tick();
    logic       xfer;
    logic [1:0] id;
    logic [7:0] d;
    xfer = out_valid_o && out_ready_i && !reset;
    id   = out_id_o;
    d    = out_data_o;
    @(posedge clk);
    #1;
    if (xfer === 1'b1) begin
      n_out++;
      xfer_ids.push_back(id);
      chk("sb_has_entry", 32'(exp_q[id].size() != 0), 32'd1);
      if (exp_q[id].size() != 0) chk("sb_data", 32'(d), 32'(exp_q[id].pop_front()));
    end
  endtask

  initial begin
    int         rr;
    int         base;
    int         idx;
    logic [3:0] mask;
    reset       = 1'b1;
    in_valid_i  = 4'hF;
    in_data_i   = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    gnt_i       = '0;
    out_ready_i = 1'b1;

    // Reset held two cycles with pushes presented
    tick();
    tick();
    chk("rst_req", 32'(req_o), 32'h0);
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_out_data", 32'(out_data_o), 32'h0);
    chk("rst_out_id", 32'(out_id_o), 32'h0);
    chk("rst_gnt_err", 32'(gnt_err_o), 32'h0);
    chk("rst_in_ready", 32'(in_ready_o), 32'h0);
    reset      = 1'b0;
    in_valid_i = '0;
    tick();
    chk("post_rst_ready", 32'(in_ready_o), 32'hF);
    chk("post_rst_req", 32'(req_o), 32'h0);

    // Single push on requester 2 and grant
    in_valid_i   = 4'b0100;
    in_data_i[2] = 8'hA5;
    exp_q[2].push_back(8'hA5);
    tick();
    in_valid_i = '0;
    chk("push2_req", 32'(req_o), 32'b0100);
    gnt_i = 4'b0100;
    tick();
    gnt_i = '0;
    chk("g2_valid", 32'(out_valid_o), 32'h1);
    chk("g2_data", 32'(out_data_o), 32'hA5);
    chk("g2_id", 32'(out_id_o), 32'h2);
    chk("g2_req", 32'(req_o), 32'h0);
    chk("g2_err", 32'(gnt_err_o), 32'h0);
    tick();
    chk("g2_drained", 32'(out_valid_o), 32'h0);

    // Fill requester 0; third push must be refused
    in_valid_i   = 4'b0001;
    in_data_i[0] = 8'h11;
    chk("r0_ready0", 32'(in_ready_o[0]), 32'h1);
    exp_q[0].push_back(8'h11);
    tick();
    in_data_i[0] = 8'h22;
    exp_q[0].push_back(8'h22);
    tick();
    chk("r0_full_ready", 32'(in_ready_o[0]), 32'h0);
    in_data_i[0] = 8'h33;
    tick();
    in_valid_i = '0;
    chk("r0_full_hold", 32'(in_ready_o[0]), 32'h0);
    gnt_i = 4'b0001;
    tick();
    chk("r0_first", 32'(out_data_o), 32'h11);
    tick();
    chk("r0_second", 32'(out_data_o), 32'h22);
    gnt_i = '0;
    tick();
    chk("r0_empty_req", 32'(req_o), 32'h0);
    chk("r0_out_idle", 32'(out_valid_o), 32'h0);

    // Simultaneous push and pop on requester 1 keeps occupancy
    in_valid_i   = 4'b0010;
    in_data_i[1] = 8'h40;
    exp_q[1].push_back(8'h40);
    tick();
    in_data_i[1] = 8'h41;
    exp_q[1].push_back(8'h41);
    gnt_i = 4'b0010;
    tick();
    in_valid_i = '0;
    gnt_i      = '0;
    chk("pp_req", 32'(req_o[1]), 32'h1);
    chk("pp_ready", 32'(in_ready_o[1]), 32'h1);
    chk("pp_data", 32'(out_data_o), 32'h40);
    gnt_i = 4'b0010;
    tick();
    gnt_i = '0;
    tick();
    chk("pp_done_req", 32'(req_o), 32'h0);

    // Output stall with a legal grant pending
    in_valid_i   = 4'b0001;
    in_data_i[0] = 8'h5A;
    exp_q[0].push_back(8'h5A);
    tick();
    in_data_i[0] = 8'h5B;
    exp_q[0].push_back(8'h5B);
    gnt_i = 4'b0001;
    tick();
    in_valid_i  = '0;
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 32'(out_valid_o), 32'h1);
      chk("stall_data", 32'(out_data_o), 32'h5A);
      chk("stall_id", 32'(out_id_o), 32'h0);
      chk("stall_err", 32'(gnt_err_o), 32'h0);
      chk("stall_req", 32'(req_o[0]), 32'h1);
    end
    out_ready_i = 1'b1;
    tick();
    gnt_i = '0;
    chk("stall_next", 32'(out_data_o), 32'h5B);
    tick();
    chk("stall_done", 32'(out_valid_o), 32'h0);

    // Illegal grants: multi-hot, then one-hot to an empty queue
    in_valid_i   = 4'b0001;
    in_data_i[0] = 8'h77;
    exp_q[0].push_back(8'h77);
    tick();
    in_valid_i = '0;
    gnt_i      = 4'b0011;
    tick();
    gnt_i = '0;
    chk("multi_err", 32'(gnt_err_o), 32'h1);
    chk("multi_nopop", 32'(req_o), 32'h1);
    chk("multi_noout", 32'(out_valid_o), 32'h0);
    tick();
    chk("multi_pulse", 32'(gnt_err_o), 32'h0);
    gnt_i = 4'b1000;
    tick();
    gnt_i = '0;
    chk("empty_err", 32'(gnt_err_o), 32'h1);
    chk("empty_noout", 32'(out_valid_o), 32'h0);
    tick();
    chk("empty_pulse", 32'(gnt_err_o), 32'h0);
    gnt_i = 4'b0001;
    tick();
    gnt_i = '0;
    tick();
    chk("illegal_drain", 32'(req_o), 32'h0);

    // All queues full, round-robin arbiter model, downstream always ready
    for (int k = 0; k < 2; k++) begin
      chk("fill_ready", 32'(in_ready_o), 32'hF);
      for (int r = 0; r < 4; r++) begin
        in_data_i[r] = 8'(8'h80 + 16 * r + k);
        exp_q[r].push_back(8'(8'h80 + 16 * r + k));
      end
      in_valid_i = 4'hF;
      tick();
    end
    in_valid_i = '0;
    chk("full_ready", 32'(in_ready_o), 32'h0);
    chk("full_req", 32'(req_o), 32'hF);
    xfer_ids.delete();
    base = n_out;
    rr   = 0;
    for (int c = 0; c < 40 && (n_out - base) < 8; c++) begin
      gnt_i = '0;
      for (int j = 0; j < 4; j++) begin
        idx = (rr + j) % 4;
        if (gnt_i == 4'h0 && req_o[idx]) begin
          gnt_i = 4'(1 << idx);
          rr    = (idx + 1) % 4;
        end
      end
      tick();
    end
    gnt_i = '0;
    chk("rr_count", 32'(n_out - base), 32'd8);
    if (xfer_ids.size() >= 8) begin
      for (int k = 0; k <= 4; k++) begin
        mask = '0;
        for (int j = 0; j < 4; j++) mask[xfer_ids[k + j]] = 1'b1;
        chk("rr_window", 32'(mask), 32'hF);
      end
    end
    chk("rr_empty", 32'(req_o), 32'h0);

    // Reset mid-operation discards queued and output payloads
    in_valid_i = 4'hF;
    tick();
    in_valid_i  = '0;
    gnt_i       = 4'b0001;
    out_ready_i = 1'b0;
    tick();
    gnt_i = '0;
    chk("mid_valid", 32'(out_valid_o), 32'h1);
    reset      = 1'b1;
    in_valid_i = 4'hF;
    tick();
    for (int r = 0; r < 4; r++) exp_q[r].delete();
    chk("mid_req", 32'(req_o), 32'h0);
    chk("mid_valid_clr", 32'(out_valid_o), 32'h0);
    chk("mid_data_clr", 32'(out_data_o), 32'h0);
    chk("mid_ready", 32'(in_ready_o), 32'h0);
    reset       = 1'b0;
    in_valid_i  = '0;
    out_ready_i = 1'b1;
    tick();
    chk("mid_after_req", 32'(req_o), 32'h0);
    chk("mid_after_ready", 32'(in_ready_o), 32'hF);
    chk("mid_after_valid", 32'(out_valid_o), 32'h0);

    chk("sb_left", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
